// File: rtl/dmem_sort_checker_if.sv
// Data-memory read port seen by the sort checker.
// One-cycle read latency: mem_rdata follows a mem_rd_en cycle.
interface dmem_sort_checker_if #(
    parameter int AW = 8
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_sort_checker.sv
// Scans a data-memory window and counts unsigned descending-order breaks.
// Optional CHECKSUM_EN adds a modulo-2^32 sum of the scanned words.
module dmem_sort_checker #(
    parameter int BASE_WORD = 32,
    parameter int NUM_WORDS = 96,
    parameter int AW        = 8,
    parameter int CW        = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    dmem_sort_checker_if.master  mem,
    output logic [CW-1:0]        err_unsorted,
    output logic [CW-1:0]        first_err_idx
`ifdef CHECKSUM_EN
    ,
    output logic [31:0]          checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [AW-1:0] BASE = AW'(BASE_WORD);
    localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] CMAX = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] pidx_q, pidx_d;
    logic          rvalid_q, rvalid_d;
    logic          first_q, first_d;
    logic [31:0]   prev_q, prev_d;
    logic [CW-1:0] err_q, err_d;
    logic [CW-1:0] ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef CHECKSUM_EN
    logic [31:0]   sum_q, sum_d;
`endif

    assign mem.mem_rd_en = (state_q == S_SCAN);
    assign mem.mem_addr  = (state_q == S_SCAN) ? BASE + idx_q : '0;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pidx_d   = pidx_q;
        first_d  = first_q;
        prev_d   = prev_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rvalid_d = (state_q == S_SCAN);
`ifdef CHECKSUM_EN
        sum_d    = sum_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    first_d = 1'b1;
                    err_d   = '0;
                    ferr_d  = '1;
                    busy_d  = 1'b1;
`ifdef CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_SCAN: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Returned words only arrive in SCAN/DRAIN, never alongside a start.
        if (rvalid_q) begin
            prev_d = mem.mem_rdata;
`ifdef CHECKSUM_EN
            sum_d  = sum_q + mem.mem_rdata;
`endif
            if (first_q) begin
                first_d = 1'b0;
                pidx_d  = '0;
            end else begin
                if (prev_q < mem.mem_rdata) begin
                    if (err_q != CMAX) begin
                        err_d = err_q + CW'(1);
                    end
                    if (ferr_q == '1) begin
                        ferr_d = CW'(pidx_q);
                    end
                end
                pidx_d = pidx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            pidx_q   <= '0;
            rvalid_q <= 1'b0;
            first_q  <= 1'b0;
            prev_q   <= '0;
            err_q    <= '0;
            ferr_q   <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pidx_q   <= pidx_d;
            rvalid_q <= rvalid_d;
            first_q  <= first_d;
            prev_q   <= prev_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_unsorted  = err_q;
    assign first_err_idx = ferr_q;
`ifdef CHECKSUM_EN
    assign checksum      = sum_q;
`endif

endmodule
